uart_rx_ctrl: RTL and testbench

Sequencing controller for the bit-rate UART receiver. Generates the receiver's single-cycle baud enable, arms the receiver (`ce`/`rd`), captures each completed byte into a small FIFO, and presents the bytes to the host over a valid/ready stream. Framing errors and FIFO overruns are reported as sticky flags. The block sits between the receiver and the bus-side consumer and is the only agent that drives the receiver's control inputs.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StCapture,
    StFault,
    StDrain
  } rx_state_e;

  localparam int unsigned DefDivW      = 16;
  localparam int unsigned DefFifoDepth = 4;

  localparam rx_state_e   RstState = StIdle;
  localparam logic [7:0]  RstData  = 8'h00;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO with wrapping pointers; async active-high reset.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DefFifoDepth
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  // A push while full is accepted only when the head is leaving in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Gated so the output is defined (and zero) while nothing is stored.
  assign rdata = empty ? RstData : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for the bit-rate UART receiver: baud enable, arming, byte FIFO, flags.
// Optional counters are enabled by defining UART_RX_CTRL_STATS_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = DefDivW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             clear_flags,
  output logic             baud_tick,
  output logic             rx_ce,
  output logic             rx_rd,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdc,
  input  logic             rx_error,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
`ifdef UART_RX_CTRL_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt,
  output logic [7:0]       ovr_cnt
`endif
);

  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             rdc_q, err_q;
  logic             rdc_rise, err_rise;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             push, pop, drop, fifo_full, fifo_empty;

  assign rdc_rise = rx_rdc & ~rdc_q;
  assign err_rise = rx_error & ~err_q;

  // Baud counter; >= keeps a lowered divisor from wrapping through the full range.
  always_comb begin
    baud_tick = 1'b0;
    div_cnt_d = '0;
    if (state_q != StIdle) begin
      if (div_cnt_q >= baud_div) baud_tick = 1'b1;
      else div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable) state_d = StArm;
      StArm: begin
        if (err_rise)      state_d = StFault;
        else if (rdc_rise) state_d = StCapture;
        else if (!enable)  state_d = StIdle;
      end
      StCapture: state_d = StDrain;
      StFault:   state_d = StDrain;
      StDrain: begin
        if (!rx_rdc && !rx_error) state_d = enable ? StArm : StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign rx_ce = busy;
  assign rx_rd = busy;

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign push    = (state_q == StCapture);
  assign drop    = push & fifo_full & ~pop;

  // Set events win over a simultaneous clear.
  assign frame_err_d = (state_q == StFault) | (frame_err_q & ~clear_flags);
  assign overrun_d   = drop | (overrun_q & ~clear_flags);
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RstState;
      div_cnt_q   <= '0;
      rdc_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      rdc_q       <= rx_rdc;
      err_q       <= rx_error;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rx_data),
    .pop   (pop),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q, ovr_cnt_q;

  // Counters saturate; a clear discards any event in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      ovr_cnt_q   <= '0;
    end else if (clear_flags) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      if (push && !drop && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (state_q == StFault && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      if (drop && ovr_cnt_q != '1) ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign ovr_cnt   = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model plus directed literal checks.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        clear_flags = 1'b0;
  logic        baud_tick, rx_ce, rx_rd;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdc = 1'b0;
  logic        rx_error = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        frame_err, overrun, busy;

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .baud_div    (baud_div),
    .clear_flags (clear_flags),
    .baud_tick   (baud_tick),
    .rx_ce       (rx_ce),
    .rx_rd       (rx_rd),
    .rx_data     (rx_data),
    .rx_rdc      (rx_rdc),
    .rx_error    (rx_error),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: every rdc rise (without a simultaneous error rise) while armed
  // lands in the queue on the second following edge; full-and-not-popping drops it.
  logic [7:0] q[$];
  bit m_ovr, m_ferr, m_rdc_p, m_err_p, cap_p, flt_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovr = 0; m_ferr = 0; m_rdc_p = 0; m_err_p = 0; cap_p = 0; flt_p = 0;
    end else begin
      bit pop_now, was_full, ovr_set, ferr_set, rise, erise;
      was_full = (q.size() == DEPTH);
      pop_now  = m_ready && (q.size() > 0);
      if (pop_now) void'(q.pop_front());
      ovr_set  = 0;
      if (cap_p) begin
        if (was_full && !pop_now) ovr_set = 1;
        else q.push_back(rx_data);
      end
      ferr_set = flt_p;
      m_ovr  = ovr_set | (m_ovr & !clear_flags);
      m_ferr = ferr_set | (m_ferr & !clear_flags);
      rise   = rx_rdc && !m_rdc_p;
      erise  = rx_error && !m_err_p;
      cap_p  = rise && !erise;
      flt_p  = erise;
      m_rdc_p = rx_rdc;
      m_err_p = rx_error;
    end
  end

  bit chk_on = 0;
  bit gap_chk = 0;
  bit last_ok = 0;
  longint last_tick = 0;

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("m_valid", m_valid, q.size() != 0);
      chk("m_data", m_data, (q.size() != 0) ? q[0] : 8'h00);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      if (baud_tick) begin
        if (gap_chk && last_ok) chk("tick_gap", 32'(cyc - last_tick), 32'(baud_div) + 1);
        last_tick = cyc;
        last_ok = 1;
      end
      if (!gap_chk) last_ok = 0;
    end
  end

  // Receiver stand-in: raise rdc (and error) for hold cycles, then let the controller settle.
  task automatic frame(input logic [7:0] b, input bit err, input int hold);
    chk("rx_ce_armed", rx_ce, 1'b1);
    rx_data  = b;
    rx_rdc   = 1'b1;
    rx_error = err;
    step(hold);
    rx_rdc   = 1'b0;
    rx_error = 1'b0;
    step(4);
  endtask

  task automatic drain_expect(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] e [4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_order", m_data, e[i]);
      step(1);
    end
    m_ready = 1'b0;
    chk("drained_empty", m_valid, 1'b0);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
  endtask

  bit stop_rand;

  initial begin
    int first;
    int ticks;

    // Reset state
    step(3);
    chk("reset_outputs", {baud_tick, rx_ce, rx_rd, m_data, m_valid, frame_err, overrun, busy}, 0);
    rst = 1'b0;
    chk_on = 1;
    step(2);
    chk("idle_no_tick", baud_tick, 1'b0);

    // First tick baud_div+1 cycles after enable is seen
    baud_div = 16'd3;
    enable = 1'b1;
    first = -1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (baud_tick) begin
        first = i;
        break;
      end
    end
    chk("first_tick", first, 4);
    gap_chk = 1;
    step(1);

    // A5 with exact two-cycle latency and a single push
    rx_data = 8'hA5;
    rx_rdc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("a5_not_yet", m_valid, 1'b0);
    @(negedge clk);
    chk("a5_valid", m_valid, 1'b1);
    chk("a5_data", m_data, 8'hA5);
    step(1);
    rx_rdc = 1'b0;
    step(4);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    chk("a5_one_push", m_valid, 1'b0);

    // Overrun: five bytes into a four-deep FIFO
    for (int b = 1; b <= 5; b++) frame(8'(b), 1'b0, 1);
    chk("ovr_flag", overrun, 1'b1);
    drain_expect(8'h01, 8'h02, 8'h03, 8'h04);
    pulse_clear();
    chk("ovr_cleared", overrun, 1'b0);

    // Framing error then a good frame
    frame(8'hEE, 1'b1, 2);
    chk("ferr_set", frame_err, 1'b1);
    chk("ferr_no_push", m_valid, 1'b0);
    pulse_clear();
    chk("ferr_cleared", frame_err, 1'b0);
    frame(8'h3C, 1'b0, 1);
    chk("3c_valid", m_valid, 1'b1);
    chk("3c_data", m_data, 8'h3C);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;

    // Full FIFO with a pop landing in the capture cycle
    for (int b = 0; b < 4; b++) frame(8'h10 + 8'(b), 1'b0, 1);
    rx_data = 8'h77;
    rx_rdc = 1'b1;
    step(1);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    rx_rdc = 1'b0;
    step(4);
    chk("full_pop_no_ovr", overrun, 1'b0);
    drain_expect(8'h11, 8'h12, 8'h13, 8'h77);

    // Enable dropped during DRAIN
    rx_data = 8'h55;
    rx_rdc = 1'b1;
    step(2);
    enable = 1'b0;
    gap_chk = 0;
    step(2);
    rx_rdc = 1'b0;
    step(3);
    chk("drop_en_rd", rx_rd, 1'b0);
    chk("drop_en_busy", busy, 1'b0);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (baud_tick) ticks++;
    end
    chk("drop_en_no_ticks", ticks, 0);
    chk("55_kept", m_data, 8'h55);

    // Asynchronous reset with the FIFO holding a byte
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", m_valid, 1'b0);
    chk("async_rst_all", {baud_tick, rx_ce, rx_rd, m_data, m_valid, frame_err, overrun, busy}, 0);
    step(2);
    rst = 1'b0;
    step(2);

    // Randomized segments against the model
    for (int seg = 0; seg < 4; seg++) begin
      baud_div = 16'($urandom_range(0, 5));
      enable = 1'b1;
      step(3);
      gap_chk = 1;
      stop_rand = 0;
      fork
        begin
          while (!stop_rand) begin
            m_ready = 1'($urandom_range(0, 1));
            clear_flags = ($urandom_range(0, 15) == 0);
            step(1);
          end
          m_ready = 1'b0;
          clear_flags = 1'b0;
        end
        begin
          for (int f = 0; f < 12; f++) begin
            step($urandom_range(0, 6));
            frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(1, 3));
          end
          stop_rand = 1;
        end
      join
      gap_chk = 0;
      enable = 1'b0;
      step(4);
      m_ready = 1'b1;
      step(6);
      m_ready = 1'b0;
      step(1);
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
